// File: rtl/rvvi_hart_arb.sv
// Round-robin NHART->1 RVVI retirement arbiter with a one-entry output slot; 1-cycle latency, in_ready only to the granted hart while the slot can load.
// Optional per-hart order-sequence checker enabled by `define RVVI_ARB_ORDER_CHECK_EN.
module rvvi_hart_arb #(
   parameter int NHART = 2,
   parameter int ILEN  = 32,
   parameter int XLEN  = 32,
   parameter int HW    = (NHART > 1) ? $clog2(NHART) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NHART-1:0]      in_valid,
   output logic [NHART-1:0]      in_ready,
   input  logic [NHART*64-1:0]   in_order,
   input  logic [NHART*ILEN-1:0] in_insn,
   input  logic [NHART*XLEN-1:0] in_pc_rdata,
   input  logic [NHART-1:0]      in_trap,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [HW-1:0]         out_hart,
   output logic [63:0]           out_order,
   output logic [ILEN-1:0]       out_insn,
   output logic [XLEN-1:0]       out_pc_rdata,
   output logic                  out_trap,
   output logic                  order_err,
   output logic [HW-1:0]         err_hart
);

   logic            out_valid_q;
   logic [HW-1:0]   out_hart_q;
   logic [63:0]     out_order_q;
   logic [ILEN-1:0] out_insn_q;
   logic [XLEN-1:0] out_pc_q;
   logic            out_trap_q;
   logic [HW-1:0]   rr_ptr_q, rr_ptr_d;

   logic            load, gnt_any, xfer;
   logic [HW-1:0]   gnt_idx;
   logic [63:0]     sel_order;
   logic [ILEN-1:0] sel_insn;
   logic [XLEN-1:0] sel_pc;
   logic            sel_trap;

   assign load = !out_valid_q || out_ready;
   assign xfer = load && gnt_any && !reset;

   // First valid hart at or after rr_ptr, wrapping.
   always_comb begin
      int h;
      h       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NHART; k++) begin
         h = int'(rr_ptr_q) + k;
         if (h >= NHART) h = h - NHART;
         if (!gnt_any && in_valid[h]) begin
            gnt_any = 1'b1;
            gnt_idx = h[HW-1:0];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = '0;
      if (int'(gnt_idx) != NHART - 1) rr_ptr_d = gnt_idx + 1'b1;
   end

   assign sel_order = in_order[int'(gnt_idx)*64 +: 64];
   assign sel_insn  = in_insn[int'(gnt_idx)*ILEN +: ILEN];
   assign sel_pc    = in_pc_rdata[int'(gnt_idx)*XLEN +: XLEN];
   assign sel_trap  = in_trap[gnt_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_hart_q  <= '0;
         out_order_q <= '0;
         out_insn_q  <= '0;
         out_pc_q    <= '0;
         out_trap_q  <= 1'b0;
         rr_ptr_q    <= '0;
      end else if (load) begin
         out_valid_q <= gnt_any;
         if (gnt_any) begin
            out_hart_q  <= gnt_idx;
            out_order_q <= sel_order;
            out_insn_q  <= sel_insn;
            out_pc_q    <= sel_pc;
            out_trap_q  <= sel_trap;
            rr_ptr_q    <= rr_ptr_d;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_hart     = out_hart_q;
   assign out_order    = out_order_q;
   assign out_insn     = out_insn_q;
   assign out_pc_rdata = out_pc_q;
   assign out_trap     = out_trap_q;

`ifdef RVVI_ARB_ORDER_CHECK_EN
   logic [NHART-1:0] seen_q;
   logic [63:0]      exp_q [NHART];
   logic             order_err_q;
   logic [HW-1:0]    err_hart_q;
   logic             mism;

   // The first packet from a hart only seeds the expectation.
   assign mism = seen_q[gnt_idx] && (sel_order != exp_q[gnt_idx]);

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_q      <= '0;
         order_err_q <= 1'b0;
         err_hart_q  <= '0;
         for (int i = 0; i < NHART; i++) exp_q[i] <= '0;
      end else if (xfer) begin
         seen_q[gnt_idx] <= 1'b1;
         exp_q[gnt_idx]  <= sel_order + 64'd1;
         if (mism) begin
            order_err_q <= 1'b1;
            if (!order_err_q) err_hart_q <= gnt_idx;
         end
      end
   end

   assign order_err = order_err_q;
   assign err_hart  = err_hart_q;
`else
   assign order_err = 1'b0;
   assign err_hart  = '0;
`endif

endmodule

// File: doc/rvvi_hart_arb.md
# rvvi_hart_arb

Round-robin arbiter that shares a single-issue RVVI retirement trace channel among NHART hart retirement sources. Each hart presents one retired instruction at a time through a valid/ready handshake. The block grants one hart per cycle, registers the winning packet into a one-entry output stage and tags it with the hart index. It sits between the per-hart retirement taps and the host-side RVVI consumer, and optionally checks each hart's `order` sequence for gaps or reuse.

## Interface
Parameters:
- `NHART`, 2 — number of hart sources (≥1)
- `ILEN`, 32 — instruction width
- `XLEN`, 32 — PC width
- `HW`, derived — hart index width, max(1, $clog2(NHART))

Ports (reset is synchronous and active-high; one clock domain):
- `clk`  in  1  interface clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  NHART  per-hart retirement valid
- `in_ready`  out  NHART  per-hart accept
- `in_order`  in  NHART×64  per-hart order count
- `in_insn`  in  NHART×ILEN  per-hart instruction
- `in_pc_rdata`  in  NHART×XLEN  per-hart PC
- `in_trap`  in  NHART  per-hart trap flag
- `out_valid`  out  1  output packet valid
- `out_ready`  in  1  consumer accept
- `out_hart`  out  HW  source hart of output packet
- `out_order`  out  64  order
- `out_insn`  out  ILEN  instruction
- `out_pc_rdata`  out  XLEN  PC
- `out_trap`  out  1  trap
- `order_err`  out  1  sticky order-sequence error
- `err_hart`  out  HW  hart of first order error

## Operation
- Output stage: one register slot. `load = !out_valid || out_ready`.
- Grant: scan harts starting at `rr_ptr`, ascending with wrap. The first hart with `in_valid` wins. `in_ready[h] = load && grant[h]`; at most one bit of `in_ready` is high per cycle.
- `in_ready` does not depend on that hart's own `in_valid` beyond the grant. Sources hold their data stable while `in_valid && !in_ready`.
- On a transfer (`in_valid[h] && in_ready[h]`):
  - the slot loads the hart's fields and `out_hart = h`;
  - `out_valid` is set;
  - `rr_ptr` becomes (h+1) mod NHART.
- `load` with no requester clears `out_valid`. `rr_ptr` is unchanged.
- `out_valid && !out_ready` holds all `out_*` stable.
- NHART=1: the grant is always hart 0 and `rr_ptr` stays 0.

## Timing
- Reset values: `out_valid`=0, `in_ready`=0 while `reset` is high, `rr_ptr`=0, `order_err`=0, `err_hart`=0, all data outputs 0, per-hart check state cleared.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 packet per cycle with `out_ready` held high. A drain and a load in the same cycle are legal.
- Fairness: with all harts continuously valid, grants rotate 0,1,…,NHART-1. No hart waits more than NHART-1 transfers.
- Reset asserted mid-stream: the output packet is dropped and the next grant starts from hart 0.

## Configuration
Macro `RVVI_ARB_ORDER_CHECK_EN`.

Defined:
- Per hart, a `seen` flag and a 64-bit `expected` register.
- The first transfer from a hart sets `seen` and `expected = in_order+1`.
- A later transfer with `in_order != expected` sets `order_err` sticky.
- `err_hart` latches only on the first error.
- `expected` always updates to `in_order+1`, modulo 2^64; 2^64-1 → 0 is legal.
- The packet is forwarded regardless of the check result.

Undefined:
- The check logic is absent.
- `order_err` and `err_hart` are tied to 0.

## Test plan
- Reset: assert `reset` for 2 cycles with all `in_valid`=1 → `in_ready`=0, `out_valid`=0, `order_err`=0.
- Round-robin: NHART=2, both valid continuously, `out_ready`=1 → `out_hart` sequence 0,1,0,1. The first `out_valid` appears 1 cycle after the first transfer.
- Backpressure: `out_ready`=0 for 3 cycles while hart 1 (order 5, pc 0x80000000) is held in the slot → `out_*` stable and `in_ready`=0 throughout. Raising `out_ready` transfers hart 0's pending packet in the same cycle.
- Single requester: only hart 1 valid, orders 0,1,2 → output orders 0,1,2, all with `out_hart`=1, back-to-back.
- Order check (macro defined): hart 0 sends orders 7 then 9 → `order_err`=1 and `err_hart`=0 the cycle after the second transfer. A later error on hart 1 leaves `err_hart`=0.
- Order wrap (macro defined): hart 0 sends order 0xFFFF_FFFF_FFFF_FFFF then 0 → `order_err` stays 0.
